// File: rtl/pong_pkg.sv
// pong_pkg: shared playfield geometry and the paddle AI state encoding.
`default_nettype none

package pong_pkg;

   localparam int SCREEN_H   = 480;
   localparam int TOP_MARGIN = 25;
   localparam int PADDLE_H   = 72;
   localparam int BALL_SIZE  = 8;

   typedef enum logic [1:0] {
      AI_IDLE   = 2'd0,
      AI_RETURN = 2'd1,
      AI_WAIT   = 2'd2,
      AI_TRACK  = 2'd3
   } ai_state_t;

endpackage

`default_nettype wire

// File: rtl/paddle_ai_lfsr.sv
// paddle_ai_lfsr: 8-bit Fibonacci LFSR (taps 8,6,5,4), steps when en_i is high.
`default_nettype none

module paddle_ai_lfsr (
   input  logic       clk,
   input  logic       reset,
   input  logic       en_i,
   input  logic [7:0] seed_i,
   output logic [7:0] state_o
);

   logic [7:0] state_q;
   logic       fb;

   assign fb      = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];
   assign state_o = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= seed_i;
      end else if (en_i) begin
         state_q <= {state_q[6:0], fb};
      end
   end

endmodule

`default_nettype wire

// File: rtl/paddle_ai.sv
// paddle_ai: right-paddle opponent FSM (IDLE/RETURN/WAIT/TRACK) with rate-limited steps.
// Define PADDLE_AI_JITTER_EN to add an LFSR-driven aim offset latched on each WAIT->TRACK.
`default_nettype none

module paddle_ai #(
   parameter int PADDLE_H    = pong_pkg::PADDLE_H,
   parameter int TOP_MARGIN  = pong_pkg::TOP_MARGIN,
   parameter int SCREEN_H    = pong_pkg::SCREEN_H,
   parameter int BALL_SIZE   = pong_pkg::BALL_SIZE,
   parameter int AI_SPEED    = 3,
   parameter int REACT_TICKS = 4,
   parameter int DEADBAND    = 4,
   parameter int HOME_Y      = 179
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       refresh_tick,
   input  logic       game_active,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   input  logic [9:0] ball_dx,
   input  logic [9:0] ball_dy,
   output logic [9:0] paddle_y,
   output logic [1:0] ai_state,
   output logic       moving
);

   import pong_pkg::*;

   localparam int PMAX = SCREEN_H - TOP_MARGIN - PADDLE_H;
   localparam logic signed [11:0] C_BIAS = 12'(BALL_SIZE/2 - TOP_MARGIN - PADDLE_H/2);
   localparam logic signed [11:0] C_PMAX = 12'(PMAX);
   localparam logic signed [11:0] C_HOME = 12'(HOME_Y);
   localparam logic signed [11:0] C_SPD  = 12'(AI_SPEED);
   localparam logic signed [11:0] C_DB   = 12'(DEADBAND);
   localparam logic [7:0]         C_SEED = 8'hA5;

   ai_state_t   state_q;
   logic [9:0]  paddle_q;
   logic        moving_q;
   logic [7:0]  cnt_q;
   logic signed [5:0] w_offset;

   logic        w_approach;
   logic signed [11:0] w_raw, w_tgt, w_goal, w_err, w_abs, w_stp, w_new;
   logic [9:0]  w_step_y;

   // Ball position along x and vertical velocity do not steer this AI.
   logic        w_unused_inputs;
   assign w_unused_inputs = ^{ball_x, ball_dy};

`ifdef PADDLE_AI_JITTER_EN
   logic [7:0]        w_lfsr;
   logic signed [5:0] offset_q;
   logic              w_unused_lfsr;

   paddle_ai_lfsr u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .en_i    (refresh_tick),
      .seed_i  (C_SEED),
      .state_o (w_lfsr)
   );

   assign w_offset      = offset_q;
   assign w_unused_lfsr = ^w_lfsr[7:5];
`else
   logic w_unused_seed;
   assign w_offset      = 6'sd0;
   assign w_unused_seed = ^C_SEED;
`endif

   assign w_approach = !ball_dx[9] && (ball_dx != 10'd0);

   always_comb begin
      w_raw = $signed({2'b00, ball_y}) + C_BIAS + {{6{w_offset[5]}}, w_offset};
      if (w_raw < 12'sd0)
         w_tgt = 12'sd0;
      else if (w_raw > C_PMAX)
         w_tgt = C_PMAX;
      else
         w_tgt = w_raw;

      w_goal = (state_q == AI_TRACK) ? w_tgt : C_HOME;
      w_err  = w_goal - $signed({2'b00, paddle_q});
      w_abs  = w_err[11] ? -w_err : w_err;
      w_stp  = (w_abs < C_SPD) ? w_abs : C_SPD;

      if (w_abs <= C_DB)
         w_new = $signed({2'b00, paddle_q});
      else if (w_err[11])
         w_new = $signed({2'b00, paddle_q}) - w_stp;
      else
         w_new = $signed({2'b00, paddle_q}) + w_stp;

      if (w_new < 12'sd0)
         w_step_y = 10'd0;
      else if (w_new > C_PMAX)
         w_step_y = C_PMAX[9:0];
      else
         w_step_y = w_new[9:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= AI_IDLE;
         paddle_q <= 10'(HOME_Y);
         moving_q <= 1'b0;
         cnt_q    <= 8'd0;
`ifdef PADDLE_AI_JITTER_EN
         offset_q <= 6'sd0;
`endif
      end else begin
         moving_q <= 1'b0;
         if (!game_active) begin
            state_q <= AI_IDLE;
            cnt_q   <= 8'd0;
         end else begin
            // Step decision uses the state held before this edge's transition.
            if (refresh_tick && (state_q == AI_RETURN || state_q == AI_TRACK)) begin
               paddle_q <= w_step_y;
               moving_q <= (w_step_y != paddle_q);
            end
            case (state_q)
               AI_IDLE: state_q <= AI_RETURN;
               AI_RETURN: begin
                  if (w_approach) begin
                     state_q <= AI_WAIT;
                     cnt_q   <= 8'(REACT_TICKS);
                  end
               end
               AI_WAIT: begin
                  if (!w_approach) begin
                     state_q <= AI_RETURN;
                     cnt_q   <= 8'd0;
                  end else if (refresh_tick) begin
                     if (cnt_q <= 8'd1) begin
                        state_q  <= AI_TRACK;
                        cnt_q    <= 8'd0;
`ifdef PADDLE_AI_JITTER_EN
                        offset_q <= $signed(6'({1'b0, w_lfsr[4:0]}) - 6'd16);
`endif
                     end else begin
                        cnt_q <= cnt_q - 8'd1;
                     end
                  end
               end
               AI_TRACK: if (!w_approach) state_q <= AI_RETURN;
               default:  state_q <= AI_IDLE;
            endcase
         end
      end
   end

   assign paddle_y = paddle_q;
   assign ai_state = state_q;
   assign moving   = moving_q;

endmodule

`default_nettype wire
